// File: rtl/msb_fall_logger_pkg.sv
// Shared widths, the event payload type and helpers for the MSB fall logger.
// Optional MSB_FALL_LOGGER_DROP_CNT_EN adds a saturating drop counter to the top.
package msb_fall_logger_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned TS_W_DEF  = 16;
    localparam int unsigned SEQ_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned DROP_W    = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [SEQ_W_DEF-1:0] seq;
    } ev_t;

    // Occupancy needs one bit more than the pointer index to represent DEPTH itself
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/msb_fall_fifo.sv
// DEPTH-entry synchronous FIFO of event records; all status and head outputs are flops.
// Built identically with or without MSB_FALL_LOGGER_DROP_CNT_EN.
module msb_fall_fifo
    import msb_fall_logger_pkg::*;
#(
    parameter type         T     = ev_t,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1,
    localparam int unsigned LW   = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    T              head_q, head_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    // Next-state: pointers carry an extra wrap bit to tell full from empty
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_pop  = pop_i & ~empty_q;
        do_push = push_i & (~full_q | do_pop);
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = data_i;
            wr_d                = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        level_d = LW'(wr_d - rd_d);
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        head_d  = mem_d[rd_d[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            head_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            head_q  <= head_d;
        end
    end

    assign data_o  = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/msb_fall_logger.sv
// Logs a timestamp and sequence number each time the watched counter MSB falls.
// Define MSB_FALL_LOGGER_DROP_CNT_EN to add the saturating drop_cnt output.
module msb_fall_logger
    import msb_fall_logger_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned SEQ_W = SEQ_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned LW   = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [SEQ_W-1:0] ev_seq,
    output logic [LW-1:0]    level,
    output logic             ovf
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SEQ_W-1:0] seq;
    } ev_w_t;

    logic             msb_q, msb_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             ovf_q, ovf_d;
    logic             fall_c, pop_c, push_c, drop_c;
    logic             fifo_full, fifo_empty;
    ev_w_t            push_data, head;
    logic [CNT_W-2:0] cnt_unused;
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

    // Only the MSB of the upstream counter matters here
    assign cnt_unused = cnt_i[CNT_W-2:0];

    // A push into a full FIFO survives only if the head leaves in the same cycle
    always_comb begin
        msb_d     = cnt_i[CNT_W-1];
        ts_d      = ts_q + TS_W'(1);
        seq_d     = seq_q;
        ovf_d     = ovf_q;
        fall_c    = msb_q & ~cnt_i[CNT_W-1] & en;
        pop_c     = ~fifo_empty & ev_ready;
        push_c    = fall_c & (~fifo_full | pop_c);
        drop_c    = fall_c & fifo_full & ~pop_c;
        push_data = '{ts: ts_q, seq: seq_q};
        if (push_c) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end
    end

`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_c && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_q <= 1'b0;
            ts_q  <= '0;
            seq_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            msb_q <= msb_d;
            ts_q  <= ts_d;
            seq_q <= seq_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    msb_fall_fifo #(
        .T     (ev_w_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  (push_data),
        .pop_i   (pop_c),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign ev_valid = ~fifo_empty;
    assign ev_ts    = head.ts;
    assign ev_seq   = head.seq;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_msb_fall_logger.sv
// Scoreboard bench for msb_fall_logger: directed scenarios queue hand-computed events,
// a negedge monitor pops and compares on every accepted handshake.
module tb_msb_fall_logger;

    localparam int unsigned TS_W  = 16;
    localparam int unsigned SEQ_W = 8;
    localparam int unsigned LW    = 3;

    typedef struct packed {
        logic [31:0]      t;
        logic [TS_W-1:0]  ts;
        logic [SEQ_W-1:0] seq;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [3:0]       cnt_i;
    logic             ev_valid;
    logic             ev_ready;
    logic [TS_W-1:0]  ev_ts;
    logic [SEQ_W-1:0] ev_seq;
    logic [LW-1:0]    level;
    logic             ovf;
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    exp_t sb_q[$];
    exp_t mon_e;
    int   total;
    int   bad;
    int   t;
    int   sc;

    msb_fall_logger dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cnt_i    (cnt_i),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ts    (ev_ts),
        .ev_seq   (ev_seq),
        .level    (level),
        .ovf      (ovf)
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
        end
    endtask

    task automatic push_exp(input int pt, input int ts, input int seq);
        sb_q.push_back('{t: 32'(pt), ts: TS_W'(ts), seq: SEQ_W'(seq)});
    endtask

    // Stimulus as a function of scenario and cycle index since reset release
    task automatic apply();
        if (sc == 2) cnt_i = (t < 3) ? 4'hF : 4'((t - 3) % 16);
        else         cnt_i = 4'(t % 16);
        en = (sc == 5) ? !(t >= 30 && t <= 34) : 1'b1;
        case (sc)
            3:       ev_ready = (t >= 100);
            4:       ev_ready = (t == 80) || (t >= 90);
            6:       ev_ready = 1'b0;
            default: ev_ready = 1'b1;
        endcase
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        t     = 0;
        apply();
        repeat (3) @(negedge clk);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_level",    int'(level),    0);
        chk("rst_ovf",      int'(ovf),      0);
        chk("rst_ev_ts",    int'(ev_ts),    0);
        chk("rst_ev_seq",   int'(ev_seq),   0);
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
        chk("rst_drop_cnt", int'(drop_cnt), 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t     = 0;
        apply();
    endtask

    task automatic checks();
        if (sc == 1 && t == 16) chk("s1_valid_before", int'(ev_valid), 0);
        if (sc == 1 && t == 17) chk("s1_valid_rise",   int'(ev_valid), 1);
        if (sc == 1 && t == 18) chk("s1_valid_fall",   int'(ev_valid), 0);
        if (sc == 2 && t == 2)  chk("s2_no_early_ev",  int'(level),    0);
        if (sc == 3 && t == 65) chk("s3_level_full",   int'(level),    4);
        if (sc == 3 && t == 80) chk("s3_ovf_before",   int'(ovf),      0);
        if (sc == 3 && t == 81) chk("s3_ovf_set",      int'(ovf),      1);
`ifdef MSB_FALL_LOGGER_DROP_CNT_EN
        if (sc == 3 && t == 97) chk("s3_drop_cnt",     int'(drop_cnt), 2);
`endif
        if (sc == 3 && t == 99)  chk("s3_level_held",  int'(level),    4);
        if (sc == 3 && t == 104) chk("s3_drained",     int'(level),    0);
        if (sc == 3 && t == 119) chk("s3_ovf_sticky",  int'(ovf),      1);
        if (sc == 4 && t == 80)  chk("s4_level_pre",   int'(level),    4);
        if (sc == 4 && t == 81)  chk("s4_level_post",  int'(level),    4);
        if (sc == 4 && t == 81)  chk("s4_no_ovf",      int'(ovf),      0);
        if (sc == 4 && t == 99)  chk("s4_no_ovf_end",  int'(ovf),      0);
        if (sc == 5 && t == 40)  chk("s5_gated_level", int'(level),    0);
        if (sc == 6 && t == 49)  chk("s6_level3",      int'(level),    3);
    endtask

    task automatic run_to(input int last);
        while (t < last) begin
            @(negedge clk);
            checks();
            @(posedge clk);
            #1;
            t++;
            apply();
        end
    endtask

    task automatic end_sc(input string name);
        @(negedge clk);
        chk(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: every accepted handshake must match the next queued event and its cycle
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event t=%0d actual ts=%0d seq=%0d required none",
                         t, ev_ts, ev_seq);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pop_cycle", t, int'(mon_e.t));
                chk("ev_ts",     int'(ev_ts),  int'(mon_e.ts));
                chk("ev_seq",    int'(ev_seq), int'(mon_e.seq));
            end
        end
    end

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        cnt_i    = '0;
        ev_ready = 1'b0;
        total    = 0;
        bad      = 0;
        t        = 0;

        sc = 1;
        push_exp(17, 16, 0);
        push_exp(33, 32, 1);
        push_exp(49, 48, 2);
        reset_dut();
        run_to(60);
        end_sc("s1_sb_empty");

        sc = 2;
        push_exp(4, 3, 0);
        reset_dut();
        run_to(18);
        end_sc("s2_sb_empty");

        sc = 3;
        push_exp(100, 16, 0);
        push_exp(101, 32, 1);
        push_exp(102, 48, 2);
        push_exp(103, 64, 3);
        push_exp(113, 112, 4);
        reset_dut();
        run_to(120);
        end_sc("s3_sb_empty");

        sc = 4;
        push_exp(80, 16, 0);
        push_exp(90, 32, 1);
        push_exp(91, 48, 2);
        push_exp(92, 64, 3);
        push_exp(93, 80, 4);
        push_exp(97, 96, 5);
        reset_dut();
        run_to(100);
        end_sc("s4_sb_empty");

        sc = 5;
        push_exp(17, 16, 0);
        push_exp(49, 48, 1);
        reset_dut();
        run_to(55);
        end_sc("s5_sb_empty");

        sc = 6;
        reset_dut();
        run_to(50);
        rst_n = 1'b0;
        #1;
        chk("s6_async_valid", int'(ev_valid), 0);
        chk("s6_async_level", int'(level),    0);
        chk("s6_async_ovf",   int'(ovf),      0);
        chk("s6_async_ts",    int'(ev_ts),    0);
        sc = 1;
        push_exp(17, 16, 0);
        reset_dut();
        run_to(30);
        end_sc("s6_sb_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
